// File: rtl/sobel_threshold_pkg.sv
// Shared frame geometry, widths, FSM states and Sobel helper for the edge-map path.
package sobel_threshold_pkg;

  localparam int unsigned IMG_W = 150;
  localparam int unsigned IMG_H = 150;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned CNT_W = 15;
  localparam int unsigned MAG_W = 11;

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  // 1-2-1 weighted sum of three pixels
  function automatic logic [MAG_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return MAG_W'(a) + (MAG_W'(b) << 1) + MAG_W'(c);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel delay: dout is the value written DEPTH enables earlier.
module line_buffer
  import sobel_threshold_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_W,
  parameter int unsigned WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sobel_threshold.sv
// Streaming 3x3 Sobel |Gx|+|Gy| with programmable threshold; one edge bit per pixel.
module sobel_threshold
  import sobel_threshold_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MAG_W-1:0] threshold,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             edge_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_d;
  logic   advance, inject, emit, load, finish;

  logic [CNT_W-1:0] in_cnt, jcnt;
  logic [COL_W-1:0] jcol;
  logic [ROW_W-1:0] jrow;
  logic [MAG_W-1:0] thr_q;

  logic [PIX_W-1:0] pix_cur, mid_tap, top_tap;
  logic [PIX_W-1:0] t0, m0, b0, t1, m1, b1;

  logic signed [MAG_W:0] gx, gy;
  logic [MAG_W-1:0]      ax, ay, mag;
  logic                  interior, edge_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    inject  = 1'b0;
    emit    = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = FILL;
      end
      FILL: if (pix_valid) begin
        advance = 1'b1;
        if (in_cnt == FILL_LAST) state_d = RUN;
      end
      RUN: if (pix_valid) begin
        advance = 1'b1;
        emit    = 1'b1;
        if (in_cnt == LAST_PIX) state_d = FLUSH;
      end
      FLUSH: begin
        advance = 1'b1;
        inject  = 1'b1;
        emit    = 1'b1;
        if (jcnt == LAST_PIX) state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix_cur = inject ? '0 : pix_in;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
    .clk(clk), .reset(reset), .en(advance), .din(pix_cur), .dout(mid_tap)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
    .clk(clk), .reset(reset), .en(advance), .din(mid_tap), .dout(top_tap)
  );

  // Right window column is the live taps; the two older columns are registered,
  // so the centre lands on pixel k-IMG_W-1 while pixel k is being accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {t0, m0, b0, t1, m1, b1} <= '0;
    end else if (advance) begin
      t0 <= t1;      m0 <= m1;      b0 <= b1;
      t1 <= top_tap; m1 <= mid_tap; b1 <= pix_cur;
    end
  end

  always_comb begin
    gx = $signed({1'b0, wsum(top_tap, mid_tap, pix_cur)}) - $signed({1'b0, wsum(t0, m0, b0)});
    gy = $signed({1'b0, wsum(b0, b1, pix_cur)}) - $signed({1'b0, wsum(t0, t1, top_tap)});
    ax = gx[MAG_W] ? MAG_W'(-gx) : MAG_W'(gx);
    ay = gy[MAG_W] ? MAG_W'(-gy) : MAG_W'(gy);
    mag = ax + ay;
    interior = (jrow != '0) && (jrow != ROW_LAST) && (jcol != '0) && (jcol != COL_LAST);
    edge_d = interior && (mag > thr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt    <= '0;
      jcnt      <= '0;
      jcol      <= '0;
      jrow      <= '0;
      thr_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      cnt_out   <= '0;
      edge_out  <= 1'b0;
    end else begin
      done      <= finish;
      out_valid <= emit;
      if (load) begin
        in_cnt <= '0;
        jcnt   <= '0;
        jcol   <= '0;
        jrow   <= '0;
        thr_q  <= threshold;
        busy   <= 1'b1;
      end
      if (finish) busy <= 1'b0;
      if (advance && !inject) in_cnt <= in_cnt + CNT_W'(1);
      if (emit) begin
        cnt_out  <= jcnt;
        edge_out <= edge_d;
        jcnt     <= jcnt + CNT_W'(1);
        if (jcol == COL_LAST) begin
          jcol <= '0;
          jrow <= jrow + ROW_W'(1);
        end else begin
          jcol <= jcol + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/sobel_threshold.md
Name: sobel_threshold

Overview:
- Streaming stage directly upstream of the edge-map buffer.
- Accepts one 8-bit greyscale pixel per cycle in raster order and computes the 3x3 Sobel gradient magnitude |Gx|+|Gy|.
- Compares the magnitude against a programmable threshold and emits one edge bit per pixel, together with that pixel's linear index.
- Output bit and index map one-to-one onto the buffer's arrayIn/cnt inputs; frame is 150x150 = 22500 pixels.

Parameters:
- IMG_W, 150, image width in pixels
- IMG_H, 150, image height in pixels
- PIX_W, 8, input pixel width
- CNT_W, 15, pixel index width; must satisfy 2^CNT_W >= IMG_W*IMG_H
- MAG_W, 11, magnitude width; max |Gx|+|Gy| = 2040

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle pulse; begins a frame, samples threshold
- threshold  in  MAG_W  edge threshold, sampled on start only
- pix_valid  in  1  pix_in valid this cycle
- pix_in  in  PIX_W  pixel data, raster order
- edge_out  out  1  edge decision for pixel cnt_out
- cnt_out  out  CNT_W  linear index of the output pixel
- out_valid  out  1  edge_out/cnt_out valid this cycle
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse after the last output

Behaviour:
- Reset (reset=0, asynchronous): edge_out=0, cnt_out=0, out_valid=0, busy=0, done=0, state=IDLE. Line buffers, counters and threshold register cleared.
- States:
  - IDLE: wait for start; ignore pix_valid. On start, sample threshold, zero counters, set busy, go to FILL.
  - FILL: accept pixels with no output until IMG_W+1 pixels are accepted, then go to RUN.
  - RUN: each accepted pixel k produces the output for pixel j = k-IMG_W-1. The last accepted pixel (k = IMG_W*IMG_H-1) moves the state to FLUSH.
  - FLUSH: internally inject IMG_W+1 zero pixels, one per clock with no stalls. These produce outputs j = 22349..22499. After the last one, go to DONE.
  - DONE: assert done for exactly one cycle, clear busy, return to IDLE.
- Latency:
  - outputs are registered and appear the cycle after the accepting pix_valid (or the flush cycle);
  - out_valid is high only then;
  - cnt_out increments strictly by 1 from 0 to 22499, with no gaps or repeats.
- Stalls: pix_valid=0 in FILL/RUN freezes all state; out_valid=0 that cycle.
- Ignored inputs: pix_valid in IDLE/FLUSH/DONE; start while busy; threshold changes after start.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1): edge_out=0 regardless of data. Neighbours never wrap across rows or frames.
- Arithmetic for interior pixels:
  - Gx = (right column weighted 1,2,1) minus (left column weighted 1,2,1);
  - Gy = (bottom row weighted 1,2,1) minus (top row weighted 1,2,1);
  - both signed, 11 bits plus sign;
  - mag = |Gx|+|Gy|, unsigned MAG_W bits, no saturation needed;
  - edge_out = (mag > threshold), strict compare, so mag == threshold gives 0.
- Reset mid-frame aborts immediately with no done pulse; the next start runs a clean frame.

Decomposition:
- Shared constants file/package: IMG_W, IMG_H, PIX_W, CNT_W, MAG_W, state encodings (IDLE, FILL, RUN, FLUSH, DONE). The buffer stage uses the same IMG_W/IMG_H/CNT_W.
- One sub-module, line_buffer: an IMG_W-deep PIX_W-wide shift delay with enable. Instantiate twice to form the 3-row window.
- Column/row counters, window registers, Sobel arithmetic and FSM stay in sobel_threshold.

Test Plan:
- All-zero frame, threshold=0, continuous pix_valid -> exactly 22500 out_valid pulses; cnt_out 0..22499 in order; all edge_out=0; one done pulse the cycle after cnt_out=22499; busy low afterwards.
- Vertical step (cols 0..74 = 0, cols 75..149 = 255), threshold=100 -> edge_out=1 exactly for rows 1..148 at cols 74 and 75 (mag=1020); all others 0.
- Same step image with random pix_valid gaps (~30%) -> identical output sequence to the previous scenario; out_valid never asserted on stall cycles; the 151 flush outputs are contiguous.
- Random image, threshold=0 -> every border index (e.g. cnt 0, 149, 150, 22350, 22499) gives 0. Interior bits match a software Sobel model.
- Threshold equality: horizontal step giving mag=1020, threshold=1020 -> all 0. Rerun with threshold=1019 -> edge rows set. Changing threshold mid-frame has no effect.
- Drive reset low at input pixel 10000 -> out_valid/busy/done drop asynchronously; no done pulse. After a new start and full frame, 22500 correct outputs.
